// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle 8-bit shift sequencer.
// A request (operand, op, amount) is taken over a valid/ready handshake. The
// sequencer then walks an internal step shifter that moves at most 3 positions
// per cycle until the full distance has been covered. The result is returned
// over a second valid/ready handshake. Every output is driven from a flop.
module shift_seq_ctrl #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       d_in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       d_out,
  output logic             busy,
  output logic [1:0]       step_shamt
);

  // Shift operation encodings as they arrive on the op port.
  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state;
  logic [7:0]       data_r;
  logic [1:0]       op_r;
  logic [AMT_W-1:0] rem_r;

  // Next-step values computed from the working registers.
  logic [1:0]       step;
  logic [AMT_W-1:0] rem_next;
  logic [7:0]       data_next;

  // Largest step the shifter can take toward the remaining distance.
  function automatic logic [1:0] min3(input logic [AMT_W-1:0] rem);
    if (rem >= AMT_W'(3)) return 2'd3;
    return rem[1:0];
  endfunction

  // One pass through the 0..3 position step shifter.
  function automatic logic [7:0] step_shift(input logic [7:0] d,
                                            input logic [1:0] o,
                                            input logic [1:0] sh);
    logic [15:0] dbl;
    logic [7:0]  res;
    // Rotating a doubled copy right leaves the rotated byte in the low half.
    dbl = {d, d} >> sh;
    case (o)
      OP_LSR:  res = d >> sh;
      OP_LSL:  res = d << sh;
      OP_ASR:  res = $unsigned($signed(d) >>> sh);
      OP_ROR:  res = dbl[7:0];
      default: res = d;
    endcase
    return res;
  endfunction

  // Step size, remaining distance and shifted data for the current BUSY cycle.
  // NOTE: every always_comb output gets a value on every path (here a plain
  // straight-line assignment) so no latch can be inferred.
  always_comb begin
    step      = min3(rem_r);
    rem_next  = rem_r - AMT_W'(step);
    data_next = step_shift(data_r, op_r, step);
  end

  // Sequencer FSM with registered handshake, status and result outputs.
  // NOTE: state and outputs use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      d_out      <= 8'h00;
      step_shamt <= 2'd0;
      data_r     <= 8'h00;
      op_r       <= OP_LSR;
      rem_r      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_r   <= d_in;
            op_r     <= op;
            rem_r    <= amount;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (amount == '0) begin
              // Zero-distance request: the operand is already the result.
              state      <= S_DONE;
              out_valid  <= 1'b1;
              d_out      <= d_in;
              step_shamt <= 2'd0;
            end else begin
              state      <= S_BUSY;
              step_shamt <= min3(amount);
            end
          end
        end

        S_BUSY: begin
          data_r <= data_next;
          rem_r  <= rem_next;
          if (rem_next == '0) begin
            state      <= S_DONE;
            out_valid  <= 1'b1;
            d_out      <= data_next;
            step_shamt <= 2'd0;
          end else begin
            // Announce the step the shifter will take in the next BUSY cycle.
            step_shamt <= min3(rem_next);
          end
        end

        S_DONE: begin
          // Result is held until taken; no new request in the handoff cycle.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          in_ready   <= 1'b1;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          step_shamt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed vector table plus hand-written sequences for
// backpressure, reset abort and back-to-back requests.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d_in;
  logic [1:0] op;
  logic [3:0] amount;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d_out;
  logic       busy;
  logic [1:0] step_shamt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] LSR = 2'b00;
  localparam logic [1:0] LSL = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  typedef struct {
    logic [1:0] op;
    logic [7:0] d_in;
    logic [3:0] amount;
    logic [7:0] exp_dout;
    int         exp_lat;
  } vec_t;

  vec_t vecs[12];

  shift_seq_ctrl #(.AMT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d_in       (d_in),
    .op         (op),
    .amount     (amount),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d_out      (d_out),
    .busy       (busy),
    .step_shamt (step_shamt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; lat counts cycles since the call.
  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({name, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  // Full request: handshake in, per-step check, result check, handoff.
  task automatic run_req(input string name, input vec_t v);
    int         lat;
    int         guard;
    logic [3:0] rem;
    logic [1:0] st;
    guard = 0;
    while (!in_ready && guard < 30) begin
      tick();
      guard++;
    end
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    d_in     = v.d_in;
    op       = v.op;
    amount   = v.amount;
    tick();
    in_valid = 1'b0;
    d_in     = 8'h00;
    amount   = 4'd0;
    lat      = 1;
    rem      = v.amount;
    while (!out_valid && lat < 30) begin
      st = (rem > 4'd3) ? 2'd3 : rem[1:0];
      check({name, "_step"}, 32'(step_shamt), 32'(st));
      rem = rem - 4'(st);
      tick();
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(v.exp_lat));
    check({name, "_dout"}, 32'(d_out), 32'(v.exp_dout));
    check({name, "_shamt_done"}, 32'(step_shamt), 32'd0);
    check({name, "_busy_done"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   lat;
    vec_t v;

    // Hand-computed vectors: op, d_in, amount, expected d_out, latency.
    vecs[0]  = '{LSR, 8'hB6, 4'd5,  8'h05, 3};
    vecs[1]  = '{ASR, 8'hB6, 4'd2,  8'hED, 2};
    vecs[2]  = '{LSR, 8'hFF, 4'd15, 8'h00, 6};
    vecs[3]  = '{ROR, 8'h81, 4'd9,  8'hC0, 4};
    vecs[4]  = '{LSL, 8'h0F, 4'd0,  8'h0F, 1};
    vecs[5]  = '{LSL, 8'h01, 4'd7,  8'h80, 4};
    vecs[6]  = '{ASR, 8'h80, 4'd15, 8'hFF, 6};
    vecs[7]  = '{ASR, 8'h7F, 4'd8,  8'h00, 4};
    vecs[8]  = '{ROR, 8'hA5, 4'd4,  8'h5A, 3};
    vecs[9]  = '{LSL, 8'hB6, 4'd3,  8'hB0, 2};
    vecs[10] = '{ROR, 8'h3C, 4'd15, 8'h78, 6};
    vecs[11] = '{LSR, 8'h80, 4'd1,  8'h40, 2};

    reset     = 1'b1;
    in_valid  = 1'b0;
    d_in      = 8'h00;
    op        = LSR;
    amount    = 4'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_dout",      32'(d_out),      32'h00);
    check("rst_shamt",     32'(step_shamt), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_req($sformatf("v%0d", i), vecs[i]);
    end

    // Backpressure: result held for 4 cycles while a new request is ignored.
    in_valid = 1'b1;
    d_in     = 8'hB6;
    op       = LSR;
    amount   = 4'd5;
    tick();
    in_valid = 1'b0;
    wait_out("bp", lat);
    check("bp_dout0", 32'(d_out), 32'h05);
    in_valid = 1'b1;
    d_in     = 8'hFF;
    op       = LSL;
    amount   = 4'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_ov%0d", i),    32'(out_valid), 32'd1);
      check($sformatf("bp_dout%0d", i),  32'(d_out),     32'h05);
      check($sformatf("bp_ready%0d", i), 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ov_drop", 32'(out_valid), 32'd0);
    check("bp_ready",   32'(in_ready),  32'd1);
    check("bp_busy",    32'(busy),      32'd0);
    tick();
    check("bp_no_accept", 32'(busy), 32'd0);

    // Reset abort in the second BUSY cycle of an amount=12 request.
    in_valid = 1'b1;
    d_in     = 8'hFF;
    op       = LSL;
    amount   = 4'd12;
    tick();
    in_valid = 1'b0;
    check("abort_busy1", 32'(busy), 32'd1);
    tick();
    check("abort_shamt2", 32'(step_shamt), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ov",    32'(out_valid),  32'd0);
    check("abort_dout",  32'(d_out),      32'h00);
    check("abort_ready", 32'(in_ready),   32'd1);
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_shamt", 32'(step_shamt), 32'd0);
    v = '{LSL, 8'h01, 4'd7, 8'h80, 4};
    run_req("post_abort", v);

    // Back-to-back with in_valid held high and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    d_in      = 8'h81;
    op        = ROR;
    amount    = 4'd9;
    tick();
    d_in   = 8'hB6;
    op     = LSR;
    amount = 4'd5;
    check("b2b_ready_busy", 32'(in_ready), 32'd0);
    wait_out("b2b_first", lat);
    check("b2b_first_lat",  32'(lat + 1), 32'd4);
    check("b2b_first_dout", 32'(d_out),   32'hC0);
    tick();
    check("b2b_handoff_ov",    32'(out_valid), 32'd0);
    check("b2b_handoff_ready", 32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_second_acc", 32'(busy), 32'd1);
    check("b2b_second_shamt", 32'(step_shamt), 32'd3);
    wait_out("b2b_second", lat);
    check("b2b_second_lat",  32'(lat + 1), 32'd3);
    check("b2b_second_dout", 32'(d_out),   32'h05);
    tick();
    out_ready = 1'b0;
    check("b2b_end_idle", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
